// File: rtl/mdu_iterative.sv
// Iterative 32-bit multiply/divide unit producing the architectural HI/LO pair.
// One multiplier/quotient bit per cycle; 32 iterations plus a sign-fix cycle.
module mdu_iterative (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t          state, state_n;
  logic [2*W-1:0]  acc, acc_n;
  logic [W-1:0]    opnd, opnd_n;
  logic [W-1:0]    orig_a, orig_a_n;
  logic            neg_lo, neg_lo_n;
  logic            neg_hi, neg_hi_n;
  logic            is_div, is_div_n;
  logic            by_zero, by_zero_n;
  logic [CW-1:0]   count, count_n;
  logic            busy_n, done_n, div_zero_n;
  logic [W-1:0]    hi_n, lo_n;

  logic            sgn;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      sum, trial, diff;
  logic [2*W-1:0]  prod;

  // Next-state and datapath: acc holds {upper, lower}; lower is the multiplier
  // being shifted out (MUL) or the dividend shifting into the quotient (DIV).
  always_comb begin
    state_n    = state;
    acc_n      = acc;
    opnd_n     = opnd;
    orig_a_n   = orig_a;
    neg_lo_n   = neg_lo;
    neg_hi_n   = neg_hi;
    is_div_n   = is_div;
    by_zero_n  = by_zero;
    count_n    = count;
    busy_n     = busy;
    done_n     = 1'b0;
    div_zero_n = div_zero;
    hi_n       = hi;
    lo_n       = lo;
    sgn        = ~op[0];
    a_mag      = (sgn && inA[W-1]) ? W'(-inA) : inA;
    b_mag      = (sgn && inB[W-1]) ? W'(-inB) : inB;
    sum        = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : '0)};
    trial      = {acc[2*W-1:W], acc[W-1]};
    diff       = trial - {1'b0, opnd};
    prod       = neg_lo ? (2*W)'(-acc) : acc;

    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              acc_n      = {{W{1'b0}}, a_mag};
              opnd_n     = b_mag;
              orig_a_n   = inA;
              is_div_n   = op[1];
              neg_lo_n   = sgn && (inA[W-1] ^ inB[W-1]);
              neg_hi_n   = op[1] ? (sgn && inA[W-1]) : (sgn && (inA[W-1] ^ inB[W-1]));
              by_zero_n  = op[1] && (inB == '0);
              count_n    = '0;
              busy_n     = 1'b1;
              div_zero_n = 1'b0;
              state_n    = op[1] ? DIV : MUL;
            end
            3'b100: begin
              hi_n       = inA;
              div_zero_n = 1'b0;
            end
            3'b101: begin
              lo_n       = inA;
              div_zero_n = 1'b0;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        acc_n   = {sum, acc[W-1:1]};
        count_n = CW'(count + CW'(1));
        if (count == LAST_ITER) state_n = FIX;
      end
      DIV: begin
        // Restoring step: keep the subtraction only if it did not borrow.
        if (!diff[W]) acc_n = {diff[W-1:0], acc[W-2:0], 1'b1};
        else          acc_n = {trial[W-1:0], acc[W-2:0], 1'b0};
        count_n = CW'(count + CW'(1));
        if (count == LAST_ITER) state_n = FIX;
      end
      FIX: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
        if (!is_div) begin
          {hi_n, lo_n} = prod;
        end else if (by_zero) begin
          lo_n       = '1;
          hi_n       = orig_a;
          div_zero_n = 1'b1;
        end else begin
          lo_n = neg_lo ? W'(-acc[W-1:0]) : acc[W-1:0];
          hi_n = neg_hi ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      opnd     <= '0;
      orig_a   <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      is_div   <= 1'b0;
      by_zero  <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      opnd     <= opnd_n;
      orig_a   <= orig_a_n;
      neg_lo   <= neg_lo_n;
      neg_hi   <= neg_hi_n;
      is_div   <= is_div_n;
      by_zero  <= by_zero_n;
      count    <= count_n;
      busy     <= busy_n;
      done     <= done_n;
      div_zero <= div_zero_n;
      hi       <= hi_n;
      lo       <= lo_n;
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: cycle-level reference model compared every cycle,
// directed literal checks for the corner cases, then randomized traffic.
module tb_mdu_iterative;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] inA   = '0;
  logic [31:0] inB   = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  mdu_iterative dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .inA(inA), .inB(inB),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  // Reference model: result computed with plain arithmetic at acceptance,
  // published 33 edges later.
  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] p_hi = '0, p_lo = '0;
  logic        p_dz = 1'b0;
  int          m_left = 0;

  task automatic compute(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rh, output logic [31:0] rl, output logic dz);
    longint      sa, sb, sq, sr;
    logic [63:0] u;
    dz = 1'b0;
    sa = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
    sb = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (!o[1]) begin
      u = 64'(sa * sb);
      rh = u[63:32];
      rl = u[31:0];
    end else if (b == 32'd0) begin
      rl = 32'hFFFFFFFF;
      rh = a;
      dz = 1'b1;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
      u  = 64'(sq);
      rl = u[31:0];
      u  = 64'(sr);
      rh = u[31:0];
    end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
          m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
        end
      end else if (start) begin
        if (op <= 3'd3) begin
          compute(op, inA, inB, p_hi, p_lo, p_dz);
          m_busy = 1'b1; m_left = 33; m_dz = 1'b0;
        end else if (op == 3'd4) begin
          m_hi = inA; m_dz = 1'b0;
        end else if (op == 3'd5) begin
          m_lo = inA; m_dz = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (checking) begin
      checks++;
      if (busy !== m_busy || done !== m_done || div_zero !== m_dz || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL model t=%0t busy/done/dz=%b%b%b hi=%h lo=%h required %b%b%b hi=%h lo=%h",
                 $time, busy, done, div_zero, hi, lo, m_busy, m_done, m_dz, m_hi, m_lo);
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1; op = o; inA = a; inB = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clock);
      cyc++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting for done after %0d cycles", cyc);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int cyc;
    issue(o, a, b);
    wait_done(cyc);
    check_lit({name, "_hi"}, hi, eh);
    check_lit({name, "_lo"}, lo, el);
    check_lit({name, "_latency"}, 32'(cyc), 32'd34);
    @(negedge clock);
    check_lit({name, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int cyc;
    #1 reset = 1'b0;
    #20;
    checking = 1'b1;
    check_lit("reset_hi", hi, 32'd0);
    check_lit("reset_busy", {31'b0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    issue(3'd4, 32'h0000AAAA, 32'd0);
    check_lit("mthi_early", hi, 32'h0000AAAA);
    issue(3'd5, 32'h00005555, 32'd0);
    check_lit("mtlo_early", lo, 32'h00005555);

    // Reset in the middle of a multiply.
    issue(3'd1, 32'h12345678, 32'h9ABCDEF0);
    repeat (9) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check_lit("midreset_busy", {31'b0, busy}, 32'd0);
    check_lit("midreset_done", {31'b0, done}, 32'd0);
    check_lit("midreset_hi", hi, 32'd0);
    check_lit("midreset_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg", 3'd0, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_min", 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run_op("divu_zero", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    check_lit("div_zero_set", {31'b0, div_zero}, 32'd1);
    issue(3'd5, 32'h00000077, 32'd0);
    check_lit("div_zero_clr", {31'b0, div_zero}, 32'd0);
    check_lit("mtlo_val", lo, 32'h00000077);

    // Start held high: second issue only after the first result is out.
    @(negedge clock);
    start = 1'b1; op = 3'd1; inA = 32'd2; inB = 32'd3;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (i == 10) begin op = 3'd4; inA = 32'h00001234; end
      if (i == 11) begin op = 3'd1; inA = 32'd2; end
      if (i == 34) begin
        check_lit("hold_done", {31'b0, done}, 32'd1);
        check_lit("hold_hi", hi, 32'd0);
        check_lit("hold_lo", lo, 32'd6);
      end
      if (i == 35) check_lit("hold_reissue_busy", {31'b0, busy}, 32'd1);
    end
    start = 1'b0;
    wait_done(cyc);
    check_lit("hold2_lo", lo, 32'd6);
    check_lit("hold2_hi", hi, 32'd0);
    issue(3'd4, 32'h00001234, 32'd0);
    check_lit("mthi_idle_hi", hi, 32'h00001234);
    check_lit("mthi_idle_done", {31'b0, done}, 32'd0);

    // Randomized traffic, including starts while busy and reserved ops.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      start = (($urandom % 4) == 0);
      op    = 3'($urandom % 8);
      inA   = rnd_val();
      inB   = rnd_val();
    end
    @(negedge clock);
    start = 1'b0;
    repeat (40) @(negedge clock);

    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
